// File: rtl/iiitb_fifo_reader_pkg.sv
// Shared definitions for the iiitb_fifo read-side drain engine: default byte
// width and the FSM state encoding (also reused by FIFO-level benches).
package iiitb_fifo_reader_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        POP       = 2'd1,
        WAIT_DATA = 2'd2,
        PRESENT   = 2'd3
    } state_e;

endpackage

// File: rtl/iiitb_fifo_reader.sv
// Read-side drain engine: pops bytes from iiitb_fifo one at a time and
// presents them on a valid/ready stream framed into BURST_LEN-byte bursts.
// Every output is either a flop or a decode of the state register, so the
// consumer never sees a combinational path from any input.
module iiitb_fifo_reader
    import iiitb_fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 4,
    parameter int COUNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               fifo_Empty,
    input  logic [DATA_W-1:0]  fifo_Data,
    output logic               fifo_Read_Enable,
    output logic [DATA_W-1:0]  out_Data,
    output logic               out_Valid,
    input  logic               out_Ready,
    output logic               out_Last,
    output logic [COUNT_W-1:0] bytes_Read,
    output logic               busy
);

    // Burst index is 8 bits wide because BURST_LEN tops out at 255.
    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 last_q, last_d;
    logic [COUNT_W-1:0]   bytes_q, bytes_d;
    logic [7:0]           idx_q, idx_d;
    logic                 can_pop;

    // Next-state and datapath updates; the FIFO is only popped from POP, and
    // POP is only entered from a cycle that saw the FIFO non-empty.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        bytes_d = bytes_q;
        idx_d   = idx_q;
        can_pop = enable && !fifo_Empty;
        case (state_q)
            IDLE: begin
                if (can_pop) state_d = POP;
            end
            POP: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                // FIFO output settled one edge after read_Enable; grab it now.
                data_d  = fifo_Data;
                last_d  = (idx_q == LAST_IDX);
                state_d = PRESENT;
            end
            PRESENT: begin
                if (out_Ready) begin
                    bytes_d = bytes_q + COUNT_W'(1);
                    idx_d   = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
                    state_d = can_pop ? POP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any byte in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            bytes_q <= '0;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
            idx_q   <= idx_d;
        end
    end

    assign fifo_Read_Enable = (state_q == POP);
    assign out_Valid        = (state_q == PRESENT);
    assign busy             = (state_q != IDLE);
    assign out_Data         = data_q;
    assign out_Last         = last_q;
    assign bytes_Read       = bytes_q;

endmodule

// File: tb/tb_iiitb_fifo_reader.sv
// Self-checking bench for iiitb_fifo_reader. A queue-based FIFO model feeds
// the DUT; a scoreboard expects bytes in push order, out_Last on every
// BURST_LEN-th delivered byte since reset, and bytes_Read = delivered mod 16.
module tb_iiitb_fifo_reader;

    localparam int BL = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_Empty;
    logic [7:0]    fifo_Data;
    logic          fifo_Read_Enable;
    logic [7:0]    out_Data;
    logic          out_Valid;
    logic          out_Ready;
    logic          out_Last;
    logic [CW-1:0] bytes_Read;
    logic          busy;

    iiitb_fifo_reader #(.DATA_W(8), .BURST_LEN(BL), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fifo_Empty(fifo_Empty),
        .fifo_Data(fifo_Data), .fifo_Read_Enable(fifo_Read_Enable),
        .out_Data(out_Data), .out_Valid(out_Valid), .out_Ready(out_Ready),
        .out_Last(out_Last), .bytes_Read(bytes_Read), .busy(busy)
    );

    always #5 clock = ~clock;

    logic [7:0]    fifo_q[$];
    logic [7:0]    exp_q[$];
    int            delivered;
    int            pops;
    int            n_checks;
    int            n_fail;
    logic [7:0]    last_hs_data;

    logic          obs_rd, obs_valid, obs_last, obs_busy;
    logic [7:0]    obs_data;
    logic [CW-1:0] obs_bytes;

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        fifo_Empty = 1'b0;
    endtask

    // One clock: score the handshake due at the coming edge, model the FIFO
    // pop just after it, then sample outputs on the falling edge.
    task automatic cycle();
        logic       hs, rd_now, rst_now, stall, was_valid, exp_last;
        logic [7:0] hd;
        logic       hl;
        logic [CW-1:0] eb;
        rst_now   = reset;
        hs        = obs_valid && out_Ready && !rst_now;
        rd_now    = obs_rd;
        stall     = obs_valid && !out_Ready && !rst_now;
        was_valid = obs_valid && !rst_now;
        hd        = obs_data;
        hl        = obs_last;
        if (hs) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got byte %02h, required no byte", obs_data);
            end else begin
                exp_last = ((delivered % BL) == BL - 1);
                if (obs_data !== exp_q[0] || obs_last !== exp_last) begin
                    n_fail++;
                    $display("FAIL sb_data: got %02h last=%0b, required %02h last=%0b",
                             obs_data, obs_last, exp_q[0], exp_last);
                end
                void'(exp_q.pop_front());
            end
            delivered++;
            last_hs_data = obs_data;
        end
        @(posedge clock);
        #1;
        if (rd_now) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_when_empty: read_Enable=1, required 0 with FIFO empty");
            end else begin
                fifo_Data = fifo_q.pop_front();
            end
            pops++;
        end
        fifo_Empty = (fifo_q.size() == 0);
        if (rst_now) delivered = 0;
        @(negedge clock);
        obs_rd    = fifo_Read_Enable;
        obs_valid = out_Valid;
        obs_last  = out_Last;
        obs_busy  = busy;
        obs_data  = out_Data;
        obs_bytes = bytes_Read;
        eb = delivered[CW-1:0];
        n_checks++;
        if (obs_bytes !== eb) begin
            n_fail++;
            $display("FAIL bytes_read: got %0d, required %0d", obs_bytes, eb);
        end
        if (was_valid && !hs && !reset) begin
            n_checks++;
            if (obs_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_drop: out_Valid=%0b, required 1", obs_valid);
            end
        end
        if (stall && !reset) begin
            n_checks++;
            if (obs_data !== hd || obs_last !== hl) begin
                n_fail++;
                $display("FAIL stall_hold: got %02h/%0b, required %02h/%0b",
                         obs_data, obs_last, hd, hl);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; out_Ready = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        fifo_q.delete(); exp_q.delete();
        fifo_Empty = 1'b1; delivered = 0; pops = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; out_Ready = 1'b1;
        cycle(); cycle();
        n_checks++;
        if ({obs_rd, obs_valid, obs_last, obs_busy, obs_data, obs_bytes} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rd=%0b v=%0b l=%0b busy=%0b d=%02h n=%0d, required all 0",
                     obs_rd, obs_valid, obs_last, obs_busy, obs_data, obs_bytes);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        push(8'h01); enable = 1'b1; out_Ready = 1'b1;
        cycle();
        n_checks++;
        if (obs_rd !== 1'b1 || obs_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_pop: rd=%0b busy=%0b, required 1/1", obs_rd, obs_busy);
        end
        cycle();
        n_checks++;
        if (obs_rd !== 1'b0 || obs_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: rd=%0b v=%0b, required 0/0", obs_rd, obs_valid);
        end
        cycle();
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h01 || obs_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_present: v=%0b d=%02h l=%0b, required 1/01/0",
                     obs_valid, obs_data, obs_last);
        end
        cycle();
        n_checks++;
        if (obs_busy !== 1'b0 || obs_bytes !== 4'd1 || pops != 1) begin
            n_fail++;
            $display("FAIL single_done: busy=%0b n=%0d pops=%0d, required 0/1/1",
                     obs_busy, obs_bytes, pops);
        end
    endtask

    task automatic test_burst();
        apply_reset();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        enable = 1'b1; out_Ready = 1'b1;
        for (int i = 0; i < 60 && delivered < 8; i++) begin
            if (obs_valid) begin
                n_checks++;
                if (obs_last !== (obs_data == 8'h13 || obs_data == 8'h17)) begin
                    n_fail++;
                    $display("FAIL burst_last: byte %02h last=%0b", obs_data, obs_last);
                end
            end
            cycle();
        end
        n_checks++;
        if (delivered != 8 || obs_bytes !== 4'd8) begin
            n_fail++;
            $display("FAIL burst_count: got %0d/%0d, required 8", delivered, obs_bytes);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push(8'hAA); push(8'hBB);
        enable = 1'b1; out_Ready = 1'b0;
        for (int i = 0; i < 10 && !obs_valid; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (obs_valid !== 1'b1 || obs_data !== 8'hAA || pops != 1) begin
                n_fail++;
                $display("FAIL bp_stall: v=%0b d=%02h pops=%0d, required 1/AA/1",
                         obs_valid, obs_data, pops);
            end
        end
        out_Ready = 1'b1;
        for (int i = 0; i < 20 && delivered < 2; i++) cycle();
        n_checks++;
        if (delivered != 2 || last_hs_data !== 8'hBB) begin
            n_fail++;
            $display("FAIL bp_second: got %0d bytes last=%02h, required 2/BB",
                     delivered, last_hs_data);
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        for (int i = 0; i < 3; i++) push(8'($urandom));
        enable = 1'b1; out_Ready = 1'b1;
        for (int i = 0; i < 10 && !obs_rd; i++) cycle();
        enable = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        n_checks++;
        if (delivered != 1 || fifo_q.size() != 2 || pops != 1) begin
            n_fail++;
            $display("FAIL en_drop: got %0d/%0d/%0d, required delivered 1, fifo 2, pops 1",
                     delivered, fifo_q.size(), pops);
        end
        enable = 1'b1;
        for (int i = 0; i < 30 && delivered < 3; i++) cycle();
        n_checks++;
        if (delivered != 3 || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL en_resume: got %0d/%0d, required delivered 3, fifo 0",
                     delivered, fifo_q.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push(8'h5A); push(8'h6B);
        enable = 1'b1; out_Ready = 1'b1;
        for (int i = 0; i < 10 && !obs_rd; i++) cycle();
        cycle();
        reset = 1'b1; enable = 1'b0;
        cycle();
        n_checks++;
        if ({obs_valid, obs_last, obs_bytes, obs_busy, obs_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%0b l=%0b n=%0d busy=%0b rd=%0b, required all 0",
                     obs_valid, obs_last, obs_bytes, obs_busy, obs_rd);
        end
        reset = 1'b0;
        void'(exp_q.pop_front());
        enable = 1'b1;
        for (int i = 0; i < 20 && delivered < 1; i++) cycle();
        n_checks++;
        if (delivered != 1 || last_hs_data !== 8'h6B) begin
            n_fail++;
            $display("FAIL reset_mid_next: got %0d bytes last=%02h, required 1/6B",
                     delivered, last_hs_data);
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] prev_b;
        logic          saw_wrap;
        apply_reset();
        for (int i = 0; i < 17; i++) push(8'($urandom));
        enable = 1'b1; out_Ready = 1'b1;
        prev_b = obs_bytes; saw_wrap = 1'b0;
        for (int i = 0; i < 100 && delivered < 17; i++) begin
            cycle();
            if (prev_b == 4'd15 && obs_bytes == 4'd0) saw_wrap = 1'b1;
            prev_b = obs_bytes;
        end
        n_checks++;
        if (!saw_wrap || obs_bytes !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap: saw_wrap=%0b final=%0d, required 1/1", saw_wrap, obs_bytes);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0 && fifo_q.size() < 16) push(8'($urandom));
            enable    = ($urandom_range(7, 0) != 0);
            out_Ready = ($urandom_range(2, 0) != 0);
            cycle();
        end
        enable = 1'b1; out_Ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || obs_busy); i++) cycle();
        n_checks++;
        if (exp_q.size() != 0 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: %0d bytes left, busy=%0b, required 0/0",
                     exp_q.size(), obs_busy);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; delivered = 0; pops = 0;
        reset = 1'b1; enable = 1'b0; out_Ready = 1'b0;
        fifo_Empty = 1'b1; fifo_Data = 8'h00; last_hs_data = 8'h00;
        obs_rd = 1'b0; obs_valid = 1'b0; obs_last = 1'b0; obs_busy = 1'b0;
        obs_data = 8'h00; obs_bytes = '0;
        @(negedge clock);
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
